imem_boot_loader: RTL and testbench

Upstream boot stage for the `single_cycle` MIPS core. It accepts a byte stream over a valid/ready interface and assembles big-endian 16-bit instruction words. It writes those words into instruction memory from address 0, verifies an XOR checksum, and only then releases the core's reset. After a successful load the core fetches from PC = 0x0000 with a fully written, verified program image.

---
 rtl/mips_boot_pkg.sv | 19 +
 rtl/imem_boot_loader_if.sv | 43 ++++
 rtl/imem_boot_loader.sv | 137 +++++++++++++
 tb/tb_imem_boot_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package mips_boot_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned INSTR_W     = 16;
    localparam int unsigned BOOT_ADDR_W = 8;
    localparam int unsigned CNT_W       = 16;

    typedef enum logic [2:0] {
        S_CNT_HI,
        S_CNT_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CHECK,
        S_DONE,
        S_ERR
    } boot_state_t;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input, instruction-memory write port and core release signals of the boot loader.
interface imem_boot_loader_if #(
    parameter int unsigned ADDR_W = mips_boot_pkg::BOOT_ADDR_W,
    parameter int unsigned DATA_W = mips_boot_pkg::INSTR_W
) ();

    logic                              in_valid;
    logic                              in_ready;
    logic [mips_boot_pkg::BYTE_W-1:0]  in_byte;
    logic                              imem_we;
    logic [ADDR_W-1:0]                 imem_addr;
    logic [DATA_W-1:0]                 imem_wdata;
    logic                              core_rst;
    logic                              load_done;
    logic                              load_err;

    // Host side: supplies the byte stream, observes memory writes and status.
    modport master (
        output in_valid,
        output in_byte,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata,
        input  core_rst,
        input  load_done,
        input  load_err
    );

    // Loader side.
    modport slave (
        input  in_valid,
        input  in_byte,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata,
        output core_rst,
        output load_done,
        output load_err
    );

endinterface

// File: rtl/imem_boot_loader.sv
// Assembles big-endian words from a counted, XOR-checksummed byte frame, writes them
// to instruction memory from address 0 and releases the core once the checksum matches.
module imem_boot_loader
    import mips_boot_pkg::*;
#(
    parameter int unsigned ADDR_W = BOOT_ADDR_W,
    parameter int unsigned DATA_W = INSTR_W
) (
    input  logic                clk,
    input  logic                rst,
    imem_boot_loader_if.slave   bus
);

    // Largest legal word count; ADDR_W is limited to 16 by the 16-bit count field.
    localparam int unsigned CAP = 32'(1) << ADDR_W;

    boot_state_t         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [BYTE_W-1:0]   hi_q, hi_d;
    logic [BYTE_W-1:0]   chk_q, chk_d;
    logic                in_ready_q, in_ready_d;
    logic                imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [DATA_W-1:0]   imem_wdata_q, imem_wdata_d;
    logic                core_rst_q, core_rst_d;
    logic                load_done_q, load_done_d;
    logic                load_err_q, load_err_d;

    logic                accept_c;
    logic [CNT_W-1:0]    n_rx_c;

    assign accept_c = bus.in_valid && in_ready_q;
    // Count high byte is parked in cnt_q[15:8] until the low byte arrives.
    assign n_rx_c   = {cnt_q[CNT_W-1:BYTE_W], bus.in_byte};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        hi_d         = hi_q;
        chk_d        = chk_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        core_rst_d   = core_rst_q;
        load_done_d  = load_done_q;
        load_err_d   = load_err_q;

        if (accept_c) begin
            chk_d = chk_q ^ bus.in_byte;
            case (state_q)
                S_CNT_HI: begin
                    cnt_d   = {bus.in_byte, BYTE_W'(0)};
                    state_d = S_CNT_LO;
                end
                S_CNT_LO: begin
                    cnt_d = n_rx_c;
                    if (32'(n_rx_c) > CAP) begin
                        state_d    = S_ERR;
                        load_err_d = 1'b1;
                    end else if (n_rx_c == CNT_W'(0)) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
                S_DATA_HI: begin
                    hi_d    = bus.in_byte;
                    state_d = S_DATA_LO;
                end
                S_DATA_LO: begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = ADDR_W'(idx_q);
                    imem_wdata_d = DATA_W'({hi_q, bus.in_byte});
                    idx_d        = idx_q + CNT_W'(1);
                    state_d      = (idx_d == cnt_q) ? S_CHECK : S_DATA_HI;
                end
                S_CHECK: begin
                    // chk_q already holds the XOR of every earlier byte in the frame.
                    if (bus.in_byte == chk_q) begin
                        state_d     = S_DONE;
                        load_done_d = 1'b1;
                        core_rst_d  = 1'b0;
                    end else begin
                        state_d    = S_ERR;
                        load_err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        in_ready_d = (state_d != S_DONE) && (state_d != S_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_CNT_HI;
            cnt_q        <= '0;
            idx_q        <= '0;
            hi_q         <= '0;
            chk_q        <= '0;
            in_ready_q   <= 1'b1;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_rst_q   <= 1'b1;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            hi_q         <= hi_d;
            chk_q        <= chk_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_rst_q   <= core_rst_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.core_rst   = core_rst_q;
    assign bus.load_done  = load_done_q;
    assign bus.load_err   = load_err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: directed frame table, reset corner sequences and random frames.
module tb_imem_boot_loader;
    import mips_boot_pkg::*;

    localparam int unsigned AW  = 8;
    localparam int          CAP = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_boot_loader_if #(.ADDR_W(AW)) bus ();
    imem_boot_loader #(.ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;

    typedef struct {
        int         len;
        logic [7:0] b [8];
        bit         done;
        bit         err;
        int         nwr;
        logic [15:0] w0;
        logic [15:0] w1;
    } vec_t;

    wr_t        got[$];
    wr_t        exp_wr[$];
    bit         exp_done, exp_err;
    logic [7:0] frame[$];
    int         checks = 0;
    int         passes = 0;
    bit         prev_we = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    endtask

    // Write monitor: collects strobes and checks strobe width and status exclusivity.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            got.push_back({bus.imem_addr, bus.imem_wdata});
            chk("strobe_width", 32'(prev_we), 32'(0));
        end
        if (bus.load_done === 1'b1 && bus.load_err === 1'b1)
            chk("done_err_excl", 32'(1), 32'(0));
        prev_we = (bus.imem_we === 1'b1);
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        got.delete();
    endtask

    // Offers one byte after a gap; returns at the negedge of the cycle after acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        int w;
        w = 0;
        for (int g = 0; g < gap; g++) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        while (bus.in_ready !== 1'b1 && w < 16) begin
            @(negedge clk);
            w++;
        end
        if (bus.in_ready !== 1'b1) begin
            chk("ready_timeout", 32'(0), 32'(1));
            bus.in_valid = 1'b0;
            ok = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        ok = 1'b1;
    endtask

    // Reference outcome of a frame computed directly from the frame format rules.
    task automatic predict();
        int n;
        logic [7:0] x;
        exp_wr.delete();
        n = {frame[0], frame[1]};
        if (n > CAP) begin
            exp_err  = 1'b1;
            exp_done = 1'b0;
        end else begin
            for (int k = 0; k < n; k++)
                exp_wr.push_back({AW'(k), frame[2 + 2 * k], frame[3 + 2 * k]});
            x = 8'h00;
            for (int i = 0; i < frame.size() - 1; i++) x = x ^ frame[i];
            exp_done = (frame[frame.size() - 1] == x);
            exp_err  = !exp_done;
        end
    endtask

    task automatic run_frame(input int gap_max);
        int  n;
        bit  legal, ok, wr_here;
        n     = {frame[0], frame[1]};
        legal = (n <= CAP);
        for (int i = 0; i < frame.size(); i++) begin
            send_byte(frame[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0, ok);
            if (!ok) break;
            wr_here = legal && (i >= 3) && (i < 2 + 2 * n) && (i % 2 == 1);
            chk("we_after_byte", 32'(bus.imem_we), 32'(wr_here));
            if (wr_here) begin
                chk("wr_addr", 32'(bus.imem_addr), 32'((i - 3) / 2));
                chk("wr_data", 32'(bus.imem_wdata), 32'({frame[i - 1], frame[i]}));
            end
        end
        chk("load_done", 32'(bus.load_done), 32'(exp_done));
        chk("load_err", 32'(bus.load_err), 32'(exp_err));
        chk("core_rst", 32'(bus.core_rst), 32'(!exp_done));
        chk("in_ready_end", 32'(bus.in_ready), 32'(!(exp_done || exp_err)));
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("wr_count", 32'(got.size()), 32'(exp_wr.size()));
        for (int k = 0; k < exp_wr.size() && k < got.size(); k++)
            chk("wr_entry", 32'(got[k]), 32'(exp_wr[k]));
    endtask

    task automatic load_nominal();
        frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    endtask

    vec_t tbl[5];

    initial begin
        bit ok;
        int n;
        logic [7:0] x;

        tbl[0].len = 7; tbl[0].b = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42, 8'h00};
        tbl[0].done = 1; tbl[0].err = 0; tbl[0].nwr = 2; tbl[0].w0 = 16'h1234; tbl[0].w1 = 16'hABCD;
        tbl[1].len = 7; tbl[1].b = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43, 8'h00};
        tbl[1].done = 0; tbl[1].err = 1; tbl[1].nwr = 2; tbl[1].w0 = 16'h1234; tbl[1].w1 = 16'hABCD;
        tbl[2].len = 2; tbl[2].b = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[2].done = 0; tbl[2].err = 1; tbl[2].nwr = 0; tbl[2].w0 = 16'h0000; tbl[2].w1 = 16'h0000;
        tbl[3].len = 3; tbl[3].b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[3].done = 1; tbl[3].err = 0; tbl[3].nwr = 0; tbl[3].w0 = 16'h0000; tbl[3].w1 = 16'h0000;
        tbl[4].len = 5; tbl[4].b = '{8'h00, 8'h01, 8'hFF, 8'h00, 8'hFE, 8'h00, 8'h00, 8'h00};
        tbl[4].done = 1; tbl[4].err = 0; tbl[4].nwr = 1; tbl[4].w0 = 16'hFF00; tbl[4].w1 = 16'h0000;

        // Reset state.
        do_reset();
        chk("rst_we", 32'(bus.imem_we), 32'(0));
        chk("rst_addr", 32'(bus.imem_addr), 32'(0));
        chk("rst_wdata", 32'(bus.imem_wdata), 32'(0));
        chk("rst_core_rst", 32'(bus.core_rst), 32'(1));
        chk("rst_done", 32'(bus.load_done), 32'(0));
        chk("rst_err", 32'(bus.load_err), 32'(0));
        chk("rst_in_ready", 32'(bus.in_ready), 32'(1));

        // Directed frame table.
        for (int t = 0; t < 5; t++) begin
            frame.delete();
            for (int i = 0; i < tbl[t].len; i++) frame.push_back(tbl[t].b[i]);
            exp_done = tbl[t].done;
            exp_err  = tbl[t].err;
            exp_wr.delete();
            for (int k = 0; k < tbl[t].nwr; k++)
                exp_wr.push_back({AW'(k), (k == 0) ? tbl[t].w0 : tbl[t].w1});
            do_reset();
            run_frame(0);
        end

        // Reset after the first write, then a full load restarts at address 0.
        do_reset();
        load_nominal();
        for (int i = 0; i < 4; i++) send_byte(frame[i], 0, ok);
        chk("mid_first_we", 32'(bus.imem_we), 32'(1));
        do_reset();
        chk("mid_core_rst", 32'(bus.core_rst), 32'(1));
        chk("mid_we", 32'(bus.imem_we), 32'(0));
        chk("mid_in_ready", 32'(bus.in_ready), 32'(1));
        predict();
        run_frame(0);

        // Reset after release puts the core back in reset.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rel_core_rst", 32'(bus.core_rst), 32'(1));
        chk("rel_done", 32'(bus.load_done), 32'(0));
        got.delete();

        // Reset in the same cycle as a LO byte drops its pending strobe.
        load_nominal();
        for (int i = 0; i < 3; i++) send_byte(frame[i], 0, ok);
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'h34;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        chk("drop_we", 32'(bus.imem_we), 32'(0));
        chk("drop_addr", 32'(bus.imem_addr), 32'(0));
        got.delete();
        predict();
        run_frame(0);

        // Nominal stream with idle gaps.
        do_reset();
        load_nominal();
        predict();
        run_frame(3);

        // Random frames; the first one fills the whole memory.
        for (int it = 0; it < 40; it++) begin
            frame.delete();
            if (it == 0) n = CAP;
            else if ($urandom_range(0, 9) == 0) n = int'($urandom_range(CAP + 1, 65535));
            else n = int'($urandom_range(0, 6));
            frame.push_back(n[15:8]);
            frame.push_back(n[7:0]);
            if (n <= CAP) begin
                for (int k = 0; k < 2 * n; k++) frame.push_back(8'($urandom));
                x = 8'h00;
                for (int i = 0; i < frame.size(); i++) x = x ^ frame[i];
                if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
                frame.push_back(x);
            end
            predict();
            do_reset();
            run_frame((it % 2 == 1) ? 3 : 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
